ss_sg_arb: RTL and testbench
============================

Name: ss_sg_arb

Overview:
- Two-requester Wishbone master arbiter that shares one system-bus master port between the source (read) and destination (write) scatter-gather engines of the DMA channel.
- Grants whole cycles, one at a time. A grant is held until the owner drops cyc.
- Routes ack/err/rty only to the owner.
- Enforces fairness by raising a per-master stop request once the owner has taken MAX_BEATS beats while the other master waits.

Parameters:
- MAX_BEATS, 16: acked beats after which the owner is asked to stop if the other master is waiting. 0 disables preemption.
- BEAT_W, 8: width of the beat counter. The counter saturates at all-ones.
- WDOG_CYCLES, 1024: stall limit for the optional watchdog.
- WDOG_W, 11: width of the watchdog counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- m0_cyc, m0_stb, m0_we, m0_pref, m0_cab  in  1 each  master 0 (source SG) bus controls
- m0_sel  in  4  master 0 byte select
- m0_adr  in  32  master 0 address
- m0_ack, m0_err, m0_rty  out  1 each  master 0 responses
- m0_stop  out  1  master 0 yield request, drives its ss_stop
- m1_cyc, m1_stb, m1_we, m1_pref, m1_cab, m1_sel, m1_adr, m1_ack, m1_err, m1_rty, m1_stop  same as m0, for master 1 (destination SG)
- s_cyc, s_stb, s_we, s_pref, s_cab  out  1 each  shared bus controls
- s_sel  out  4  shared byte select
- s_adr  out  32  shared address
- s_ack, s_err, s_rty  in  1 each  shared bus responses
- gnt  out  2  one-hot current owner, for debug
- wdog_to  out  1  watchdog timeout pulse

Behaviour:
- Reset values: state=IDLE, gnt=00, last_gnt=1 (so m0 wins the first tie), beat counter=0, watchdog counter=0.
  - All outputs are 0 during reset. s_* are 0 because no master is granted.
- Read data is not routed through this block; it is broadcast to both masters externally.
- States: IDLE, G0, G1. The state register is updated on posedge wb_clk_i or posedge wb_rst_i.
- IDLE:
  - Only m0_cyc asserted: go to G0.
  - Only m1_cyc asserted: go to G1.
  - Both asserted: grant the master that is not last_gnt.
  - Grant latency is 1 cycle from cyc assertion. s_cyc=0 while in IDLE.
- G0 / G1:
  - s_{cyc,stb,we,pref,cab,sel,adr} combinationally follow the owner's signals.
  - s_ack/s_err/s_rty pass combinationally to the owner. The non-owner's ack/err/rty are held at 0.
  - The non-owner may hold cyc for any length of time without side effects.
- Release:
  - When the owner's cyc is low while in Gx, set last_gnt=x.
  - If the other master's cyc is high, go directly to its grant (no IDLE cycle). Otherwise go to IDLE.
  - On the release cycle s_cyc=0 because it follows the owner's cyc.
- Beat counter:
  - Cleared on every grant change.
  - Increments on each cycle with s_ack=1 while granted. Saturates at 2^BEAT_W-1.
- Stop request:
  - mX_stop is registered and set when all hold: MAX_BEATS!=0, X owns the bus, count>=MAX_BEATS, the other master's cyc=1.
  - Once set it holds until X releases, then clears.
  - It never asserts for a master that does not own the bus.
- Simultaneous events:
  - Owner release and the other master's request in the same cycle: switch grant, per the release rule.
  - s_err with a pending stop request: err is still delivered and the stop is kept until release.
- Reset asserted mid-cycle: immediately return to IDLE. s_cyc drops asynchronously. No response is delivered to either master.

Optional Feature:
- Macro: SS_SG_ARB_WDOG_EN.
- Defined:
  - A watchdog counter increments on cycles with s_cyc & s_stb & !(s_ack|s_err|s_rty). It clears on any response or grant change.
  - On reaching WDOG_CYCLES: a 1-cycle mX_err pulse goes to the owner (ORed with s_err), wdog_to pulses for 1 cycle, and the counter clears.
  - The arbiter then waits for the owner to drop cyc.
- Undefined: no watchdog counter, wdog_to tied 0, and err comes only from s_err.

Test Plan:
- m0 requests alone with a 4-beat burst, slave acks each cycle:
  - gnt=01 one cycle after m0_cyc.
  - m0_ack pulses 4 times.
  - m1_ack stays 0.
  - gnt=00 one cycle after m0_cyc drops.
- m0 and m1 raise cyc in the same cycle out of reset:
  - m0 is granted first.
  - After m0 releases, gnt=10 on the next cycle with no IDLE cycle.
  - The next tie is won by m0 again, because last_gnt=1.
- MAX_BEATS=4, m0 streaming and m1 waiting from beat 1:
  - m0_stop rises the cycle after the 4th ack and holds until m0_cyc=0.
  - m1 is granted next.
  - m1_stop is never asserted while m1 is not the owner.
- s_err during an m1 beat: m1_err=1 the same cycle, m0_err=0, and the grant is held until m1 drops cyc.
- Reset asserted during an m0 burst: s_cyc=0, gnt=00 and m0_stop=0 asynchronously. After reset, a pending m1 request is granted normally.
- SS_SG_ARB_WDOG_EN defined, WDOG_CYCLES=8, slave never acks:
  - m0_err and wdog_to pulse on the 8th stalled cycle.
  - m0 drops cyc and the arbiter returns to IDLE.
  - With the macro undefined, the bus stalls indefinitely and wdog_to stays 0.

Source files
------------

// File: rtl/ss_sg_arb.sv
// Two-master Wishbone arbiter sharing one bus port between the source and destination SG engines.
// Optional stall watchdog enabled by defining SS_SG_ARB_WDOG_EN.
module ss_sg_arb #(
    parameter int MAX_BEATS   = 16,
    parameter int BEAT_W      = 8,
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic        m0_pref,
    input  logic        m0_cab,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_adr,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_rty,
    output logic        m0_stop,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic        m1_pref,
    input  logic        m1_cab,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_adr,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_rty,
    output logic        m1_stop,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic        s_pref,
    output logic        s_cab,
    output logic [3:0]  s_sel,
    output logic [31:0] s_adr,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic        s_rty,

    output logic [1:0]  gnt,
    output logic        wdog_to
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [31:0] MAX_BEATS_U = 32'(MAX_BEATS);
    localparam logic        PREEMPT_EN  = (MAX_BEATS != 0);

    state_t              state_reg, state_next;
    logic                last_gnt_reg, last_gnt_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next, beat_upd;
    logic [1:0]          stop_reg, stop_next, stop_set;
    logic [1:0]          own, own_next, req;
    logic [1:0]          rsp_ack, rsp_err, rsp_rty;
    logic                grant_change;
    logic                beat_reached;
    logic                wdog_hit;

    assign own      = {state_reg == G1, state_reg == G0};
    assign own_next = {state_next == G1, state_next == G0};
    assign req      = {m1_cyc, m0_cyc};
    assign gnt      = own;

    // Next-state: ties go to the master that did not own the bus last.
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc && m1_cyc)
                    state_next = last_gnt_reg ? G0 : G1;
                else if (m0_cyc)
                    state_next = G0;
                else if (m1_cyc)
                    state_next = G1;
            end
            G0: begin
                if (!m0_cyc) begin
                    last_gnt_next = 1'b0;
                    state_next    = m1_cyc ? G1 : IDLE;
                end
            end
            G1: begin
                if (!m1_cyc) begin
                    last_gnt_next = 1'b1;
                    state_next    = m0_cyc ? G0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_change = (state_next != state_reg);

    always_comb begin
        beat_upd = beat_cnt_reg;
        if (s_ack && (state_reg != IDLE) && !(&beat_cnt_reg))
            beat_upd = beat_cnt_reg + 1'b1;
        beat_cnt_next = grant_change ? '0 : beat_upd;
    end

    // Compare against the post-ack count so stop rises the cycle after the limiting ack.
    assign beat_reached = (32'(beat_upd) >= MAX_BEATS_U);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign rsp_ack[gi]   = own[gi] & s_ack;
            assign rsp_err[gi]   = own[gi] & (s_err | wdog_hit);
            assign rsp_rty[gi]   = own[gi] & s_rty;
            assign stop_set[gi]  = PREEMPT_EN & own[gi] & beat_reached & req[gi ^ 1];
            assign stop_next[gi] = own_next[gi] & (stop_reg[gi] | stop_set[gi]);
        end
    endgenerate

    assign m0_ack  = rsp_ack[0];
    assign m0_err  = rsp_err[0];
    assign m0_rty  = rsp_rty[0];
    assign m0_stop = stop_reg[0];
    assign m1_ack  = rsp_ack[1];
    assign m1_err  = rsp_err[1];
    assign m1_rty  = rsp_rty[1];
    assign m1_stop = stop_reg[1];

    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_pref = 1'b0;
        s_cab  = 1'b0;
        s_sel  = 4'h0;
        s_adr  = 32'h0;
        case (state_reg)
            G0: begin
                s_cyc  = m0_cyc;
                s_stb  = m0_stb;
                s_we   = m0_we;
                s_pref = m0_pref;
                s_cab  = m0_cab;
                s_sel  = m0_sel;
                s_adr  = m0_adr;
            end
            G1: begin
                s_cyc  = m1_cyc;
                s_stb  = m1_stb;
                s_we   = m1_we;
                s_pref = m1_pref;
                s_cab  = m1_cab;
                s_sel  = m1_sel;
                s_adr  = m1_adr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            beat_cnt_reg <= '0;
            stop_reg     <= 2'b00;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            beat_cnt_reg <= beat_cnt_next;
            stop_reg     <= stop_next;
        end
    end

`ifdef SS_SG_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic              stall;

    assign stall    = s_cyc & s_stb & ~(s_ack | s_err | s_rty);
    assign wdog_hit = stall && (32'(wdog_cnt_reg) == 32'(WDOG_CYCLES - 1));
    assign wdog_to  = wdog_hit;

    always_comb begin
        wdog_cnt_next = wdog_cnt_reg;
        if (grant_change || s_ack || s_err || s_rty || wdog_hit)
            wdog_cnt_next = '0;
        else if (stall)
            wdog_cnt_next = wdog_cnt_reg + 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            wdog_cnt_reg <= '0;
        else
            wdog_cnt_reg <= wdog_cnt_next;
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_to  = 1'b0;
`endif

endmodule

// File: tb/tb_ss_sg_arb.sv
// Scoreboard bench for ss_sg_arb: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Built with MAX_BEATS=4 and WDOG_CYCLES=8; watchdog expectations follow SS_SG_ARB_WDOG_EN.
module tb_ss_sg_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0;
    logic        s_ack = 0, s_err = 0;
    logic        m0_ack, m0_err, m0_rty, m0_stop;
    logic        m1_ack, m1_err, m1_rty, m1_stop;
    logic        s_cyc, s_stb, s_we, s_pref, s_cab;
    logic [3:0]  s_sel;
    logic [31:0] s_adr;
    logic [1:0]  gnt;
    logic        wdog_to;

    always #5 clk = ~clk;

    ss_sg_arb #(
        .MAX_BEATS  (4),
        .BEAT_W     (8),
        .WDOG_CYCLES(8),
        .WDOG_W     (11)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(1'b0), .m0_pref(1'b0), .m0_cab(1'b0),
        .m0_sel(4'hF), .m0_adr(32'h1000_00A0),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_stop(m0_stop),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(1'b1), .m1_pref(1'b1), .m1_cab(1'b1),
        .m1_sel(4'h3), .m1_adr(32'h2000_00B1),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_stop(m1_stop),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_pref(s_pref), .s_cab(s_cab),
        .s_sel(s_sel), .s_adr(s_adr),
        .s_ack(s_ack), .s_err(s_err), .s_rty(1'b0),
        .gnt(gnt), .wdog_to(wdog_to)
    );

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Vector layout: gnt[1:0] s_cyc s_stb | m0 ack err stop | m1 ack err stop | wdog_to | s_we | s_adr[7:0]
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [19:0] act;
            e   = exp_q.pop_front();
            act = {gnt, s_cyc, s_stb, m0_ack, m0_err, m0_stop, m1_ack, m1_err, m1_stop,
                   wdog_to, s_we, s_adr[7:0]};
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: got %05h expected %05h", e.tag, act, e.v);
            end else begin
                $display("ok   %s: %05h", e.tag, act);
            end
        end
    end

    // e: gnt(2) s_cyc s_stb | m0 ack err stop | m1 ack err stop | wdog_to
    task automatic step(input logic r, c0, s0, c1, s1, ack, err,
                        input logic [10:0] e, input string tag);
        exp_t x;
        logic [7:0] adr;
        @(posedge clk);
        #1;
        rst    = r;
        m0_cyc = c0;
        m0_stb = s0;
        m1_cyc = c1;
        m1_stb = s1;
        s_ack  = ack;
        s_err  = err;
        adr = (e[10:9] == 2'b01) ? 8'hA0 : (e[10:9] == 2'b10) ? 8'hB1 : 8'h00;
        x.v   = {e, e[10:9] == 2'b10, adr};
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    localparam logic [10:0] Z      = 11'b00_00_000_000_0;
    localparam logic [10:0] G0_ACK = 11'b01_11_100_000_0;
    localparam logic [10:0] G0_REL = 11'b01_00_000_000_0;
    localparam logic [10:0] G1_ACK = 11'b10_11_000_100_0;
    localparam logic [10:0] G1_REL = 11'b10_00_000_000_0;

    initial begin
        step(1, 0,0,0,0, 0,0, Z, "reset_idle");

        // m0 alone, 4-beat burst
        step(0, 1,1,0,0, 0,0, Z, "t1_req_latency");
        for (int i = 0; i < 4; i++)
            step(0, 1,1,0,0, 1,0, G0_ACK, $sformatf("t1_beat%0d", i));
        step(0, 0,0,0,0, 0,0, G0_REL, "t1_release");
        step(0, 0,0,0,0, 0,0, Z, "t1_idle");

        // simultaneous requests out of reset
        step(1, 0,0,0,0, 0,0, Z, "t2_reset");
        step(0, 1,1,1,1, 0,0, Z, "t2_tie_idle");
        step(0, 1,1,1,1, 1,0, G0_ACK, "t2_m0_first");
        step(0, 0,0,1,1, 0,0, G0_REL, "t2_m0_release");
        step(0, 0,0,1,1, 1,0, G1_ACK, "t2_m1_direct");
        step(0, 0,0,0,0, 0,0, G1_REL, "t2_m1_release");
        step(0, 1,1,1,1, 0,0, Z, "t2_tie2_idle");
        step(0, 1,1,1,0, 0,0, 11'b01_11_000_000_0, "t2_tie2_m0");
        step(0, 0,0,0,0, 0,0, G0_REL, "t2_tie2_release");
        step(0, 0,0,0,0, 0,0, Z, "t2_idle");

        // preemption with m1 waiting from beat 1
        step(0, 1,1,0,0, 0,0, Z, "t3_req");
        for (int i = 1; i <= 4; i++)
            step(0, 1,1,1,1, 1,0, G0_ACK, $sformatf("t3_ack%0d", i));
        step(0, 1,1,1,1, 1,0, 11'b01_11_101_000_0, "t3_stop_rise");
        step(0, 0,0,1,1, 0,0, 11'b01_00_001_000_0, "t3_stop_hold");
        step(0, 0,0,1,1, 1,0, G1_ACK, "t3_m1_granted");

        // slave error on an m1 beat
        step(0, 0,0,1,1, 0,1, 11'b10_11_000_010_0, "t4_err_m1");
        step(0, 0,0,1,0, 0,0, 11'b10_10_000_000_0, "t4_grant_held");
        step(0, 0,0,0,0, 0,0, G1_REL, "t4_release");
        step(0, 0,0,0,0, 0,0, Z, "t4_idle");

        // reset during an m0 burst with stop pending
        step(0, 1,1,0,0, 0,0, Z, "t5_req");
        for (int i = 1; i <= 4; i++)
            step(0, 1,1,1,1, 1,0, G0_ACK, $sformatf("t5_ack%0d", i));
        step(0, 1,1,1,1, 1,0, 11'b01_11_101_000_0, "t5_stop");
        step(1, 1,1,1,1, 1,0, Z, "t5_async_reset");
        step(0, 0,0,1,1, 0,0, Z, "t5_post_reset_idle");
        step(0, 0,0,1,1, 1,0, G1_ACK, "t5_m1_granted");
        step(0, 0,0,0,0, 0,0, G1_REL, "t5_release");
        step(0, 0,0,0,0, 0,0, Z, "t5_idle");

        // stalled slave
        step(0, 1,1,0,0, 0,0, Z, "t6_req");
`ifdef SS_SG_ARB_WDOG_EN
        for (int i = 1; i <= 7; i++)
            step(0, 1,1,0,0, 0,0, 11'b01_11_000_000_0, $sformatf("t6_stall%0d", i));
        step(0, 1,1,0,0, 0,0, 11'b01_11_010_000_1, "t6_wdog_fire");
`else
        for (int i = 1; i <= 20; i++)
            step(0, 1,1,0,0, 0,0, 11'b01_11_000_000_0, $sformatf("t6_stall%0d", i));
`endif
        step(0, 0,0,0,0, 0,0, G0_REL, "t6_release");
        step(0, 0,0,0,0, 0,0, Z, "t6_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
